noc_resource_iface: RTL and testbench
=====================================

Name: noc_resource_iface

Overview:
- Network interface between a processing element (PE) and the RESOURCE port of one xy_switch.
- TX side: takes destination coordinates and payload from the PE over a valid/ready handshake, builds a packet, and writes it into the switch's RESOURCE input FIFO under that FIFO's full flag.
- RX side: buffers packets the switch delivers on its RESOURCE output in a local FIFO, checks their address, and presents the payload to the PE over valid/ready.

Parameters:
- X_CORD, 0, X coordinate of the attached switch.
- Y_CORD, 0, Y coordinate of the attached switch.
- PCKT_XADDR_W, 4, X address field width.
- PCKT_YADDR_W, 4, Y address field width.
- PCKT_DATA_W, 8, payload width.
- PCKT_W, PCKT_XADDR_W+PCKT_YADDR_W+PCKT_DATA_W, packet width.
- RX_FIFO_DEPTH_W, 2, RX FIFO holds 2**RX_FIFO_DEPTH_W packets.
- CNT_W, 16, width of the packet counters.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- tx_valid_i  in  1  PE request to send.
- tx_ready_o  out  1  interface accepts the TX request this cycle.
- tx_dst_x_i  in  PCKT_XADDR_W  destination X.
- tx_dst_y_i  in  PCKT_YADDR_W  destination Y.
- tx_data_i  in  PCKT_DATA_W  payload.
- sw_wr_en_o  out  1  write strobe to the switch RESOURCE input FIFO.
- sw_pckt_o  out  PCKT_W  packet to the switch.
- sw_full_i  in  1  switch RESOURCE input FIFO full.
- sw_overflow_i  in  1  switch RESOURCE input FIFO overflow.
- sw_wr_en_i  in  1  write strobe from the switch RESOURCE output.
- sw_pckt_i  in  PCKT_W  packet from the switch.
- sw_full_o  out  1  RX FIFO full (drives the switch's nxt_fifo_full for the RESOURCE port).
- sw_overflow_o  out  1  RX overflow, sticky.
- rx_valid_o  out  1  RX payload available.
- rx_ready_i  in  1  PE consumes the RX payload.
- rx_data_o  out  PCKT_DATA_W  RX payload.
- misroute_o  out  1  sticky: a packet arrived whose address is not (X_CORD, Y_CORD).
- tx_err_o  out  1  sticky: sw_overflow_i was seen high.
- tx_cnt_o  out  CNT_W  packets written to the switch.
- rx_cnt_o  out  CNT_W  packets delivered to the PE.

Behaviour:
- Packet format: {x, y, data}. X field is the MSBs, data field is the LSBs.
- Reset values: all outputs 0, except tx_ready_o = 1 (the TX register is empty).
- Reset asserted mid-operation flushes the TX register and the RX FIFO and clears all sticky flags and counters immediately.

TX path:
- One holding register, states EMPTY and LOADED.
- tx_ready_o = EMPTY | sw_wr_en_o.
- A handshake (tx_valid_i & tx_ready_o) loads {tx_dst_x_i, tx_dst_y_i, tx_data_i} into the register and moves it to LOADED on the next edge.
- sw_wr_en_o = LOADED & ~sw_full_i. This is combinational from registered state and sw_full_i. sw_pckt_o is the register contents.
- LOADED with sw_wr_en_o = 1 and a new handshake in the same cycle: the register reloads and stays LOADED. This sustains one packet per cycle.
- LOADED with sw_wr_en_o = 1 and no handshake: go to EMPTY.
- sw_full_i held high: the register holds and sw_pckt_o stays stable. There is no drop on the TX side.
- tx_cnt_o increments (wrapping) on each sw_wr_en_o.
- tx_err_o sets on sw_overflow_i = 1 and clears only on reset.

RX path:
- Show-ahead FIFO with depth D = 2**RX_FIFO_DEPTH_W. Pointers are RX_FIFO_DEPTH_W+1 bits, using the extra bit to tell full from empty.
- sw_full_o = (count == D). rx_valid_o = (count != 0). rx_data_o is the data field of the head entry.
- Pop on rx_valid_o & rx_ready_i. rx_cnt_o increments (wrapping) on each pop.
- Push on sw_wr_en_i when the FIFO is not full, or when it is full and a pop happens in the same cycle. The pushed entry is ready to read on the following cycle.
- sw_wr_en_i while full with no pop: drop the packet and set sw_overflow_o (sticky until reset). Count and pointers are unchanged.
- Empty FIFO with rx_ready_i = 1: no pop, no error.
- Address check: a pushed packet whose x ≠ X_CORD or y ≠ Y_CORD is still stored and sets misroute_o (sticky).
- A dropped packet does not set misroute_o.

Test Plan:
- Reset, then idle. Required: tx_ready_o = 1, all other outputs 0. Send 3 packets (x=2, y=1, data=0xA0..0xA2) back-to-back with sw_full_i = 0. Required: sw_wr_en_o high for 3 consecutive cycles starting one cycle after the first handshake; sw_pckt_o = 0x21A0, 0x21A1, 0x21A2; tx_cnt_o = 3.
- Load a packet, then hold sw_full_i = 1 for 4 cycles. Required: sw_wr_en_o = 0, tx_ready_o = 0, sw_pckt_o stable. Release sw_full_i. Required: exactly one write; tx_ready_o returns to 1.
- X_CORD = Y_CORD = 0, D = 4, rx_ready_i = 0. Push 4 packets with data 0x10..0x13. Required: sw_full_o = 1 after the 4th. A 5th push sets sw_overflow_o = 1. Draining returns 0x10..0x13 in order; rx_cnt_o = 4.
- FIFO full with push and pop in the same cycle. Required: no overflow, count stays 4, the new data emerges last.
- Push a packet with x = 3. Required: misroute_o = 1 and the payload is delivered. Pulse sw_overflow_i. Required: tx_err_o = 1.
- Assert rst_ni low mid-stream, asynchronously between clock edges. Required: the FIFO empties, counters and flags are 0, and tx_ready_o = 1 immediately.

Source files
------------

// File: rtl/noc_resource_iface.sv
// Network interface between a processing element and the RESOURCE port of one xy_switch.
// TX: single holding register feeding the switch FIFO. RX: show-ahead FIFO with address check.
module noc_resource_iface #(
  parameter int X_CORD          = 0,
  parameter int Y_CORD          = 0,
  parameter int PCKT_XADDR_W    = 4,
  parameter int PCKT_YADDR_W    = 4,
  parameter int PCKT_DATA_W     = 8,
  parameter int PCKT_W          = PCKT_XADDR_W + PCKT_YADDR_W + PCKT_DATA_W,
  parameter int RX_FIFO_DEPTH_W = 2,
  parameter int CNT_W           = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    tx_valid_i,
  output logic                    tx_ready_o,
  input  logic [PCKT_XADDR_W-1:0] tx_dst_x_i,
  input  logic [PCKT_YADDR_W-1:0] tx_dst_y_i,
  input  logic [PCKT_DATA_W-1:0]  tx_data_i,
  output logic                    sw_wr_en_o,
  output logic [PCKT_W-1:0]       sw_pckt_o,
  input  logic                    sw_full_i,
  input  logic                    sw_overflow_i,
  input  logic                    sw_wr_en_i,
  input  logic [PCKT_W-1:0]       sw_pckt_i,
  output logic                    sw_full_o,
  output logic                    sw_overflow_o,
  output logic                    rx_valid_o,
  input  logic                    rx_ready_i,
  output logic [PCKT_DATA_W-1:0]  rx_data_o,
  output logic                    misroute_o,
  output logic                    tx_err_o,
  output logic [CNT_W-1:0]        tx_cnt_o,
  output logic [CNT_W-1:0]        rx_cnt_o
);

  localparam int RX_DEPTH = 2 ** RX_FIFO_DEPTH_W;
  localparam int PTR_W    = RX_FIFO_DEPTH_W + 1;

  localparam logic [0:0] TX_EMPTY  = 1'b0;
  localparam logic [0:0] TX_LOADED = 1'b1;

  // ---------------- TX path ----------------
  logic [0:0]        tx_state_q, tx_state_d;
  logic [PCKT_W-1:0] tx_pckt_q, tx_pckt_d;
  logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
  logic              tx_err_q, tx_err_d;
  logic              tx_wr_en;
  logic              tx_ready;
  logic              tx_hs;

  assign tx_wr_en = (tx_state_q == TX_LOADED) & ~sw_full_i;
  assign tx_ready = (tx_state_q == TX_EMPTY) | tx_wr_en;
  assign tx_hs    = tx_valid_i & tx_ready;

  // A handshake while the current packet drains reloads the register, sustaining one packet per cycle.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_pckt_d  = tx_pckt_q;
    tx_cnt_d   = tx_cnt_q;
    tx_err_d   = tx_err_q | sw_overflow_i;
    if (tx_hs) begin
      tx_state_d = TX_LOADED;
      tx_pckt_d  = {tx_dst_x_i, tx_dst_y_i, tx_data_i};
    end else if (tx_wr_en) begin
      tx_state_d = TX_EMPTY;
    end
    if (tx_wr_en) begin
      tx_cnt_d = tx_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_state_q <= TX_EMPTY;
      tx_pckt_q  <= '0;
      tx_cnt_q   <= '0;
      tx_err_q   <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_pckt_q  <= tx_pckt_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_err_q   <= tx_err_d;
    end
  end

  // ---------------- RX path ----------------
  logic [PCKT_DATA_W-1:0] rx_mem_q [RX_DEPTH];
  logic [PCKT_DATA_W-1:0] rx_mem_d [RX_DEPTH];
  logic [PTR_W-1:0]       rx_wr_ptr_q, rx_wr_ptr_d;
  logic [PTR_W-1:0]       rx_rd_ptr_q, rx_rd_ptr_d;
  logic [PTR_W-1:0]       rx_count;
  logic [CNT_W-1:0]       rx_cnt_q, rx_cnt_d;
  logic                   rx_ovf_q, rx_ovf_d;
  logic                   misroute_q, misroute_d;
  logic                   rx_full;
  logic                   rx_valid;
  logic                   rx_pop;
  logic                   rx_push;
  logic                   rx_drop;
  logic                   rx_addr_ok;

  logic [PCKT_XADDR_W-1:0] rx_in_x;
  logic [PCKT_YADDR_W-1:0] rx_in_y;
  logic [PCKT_DATA_W-1:0]  rx_in_data;

  assign {rx_in_x, rx_in_y, rx_in_data} = sw_pckt_i;
  assign rx_addr_ok = (rx_in_x == PCKT_XADDR_W'(X_CORD)) && (rx_in_y == PCKT_YADDR_W'(Y_CORD));

  // The extra pointer bit distinguishes a full FIFO from an empty one.
  assign rx_count = rx_wr_ptr_q - rx_rd_ptr_q;
  assign rx_full  = (rx_count == PTR_W'(RX_DEPTH));
  assign rx_valid = (rx_count != '0);
  assign rx_pop   = rx_valid & rx_ready_i;
  assign rx_push  = sw_wr_en_i & (~rx_full | rx_pop);
  assign rx_drop  = sw_wr_en_i & rx_full & ~rx_pop;

  // Only the payload is stored; the address is fully consumed by the check on entry.
  always_comb begin
    rx_mem_d    = rx_mem_q;
    rx_wr_ptr_d = rx_wr_ptr_q;
    rx_rd_ptr_d = rx_rd_ptr_q;
    rx_cnt_d    = rx_cnt_q;
    rx_ovf_d    = rx_ovf_q | rx_drop;
    misroute_d  = misroute_q | (rx_push & ~rx_addr_ok);
    if (rx_push) begin
      rx_mem_d[rx_wr_ptr_q[RX_FIFO_DEPTH_W-1:0]] = rx_in_data;
      rx_wr_ptr_d = rx_wr_ptr_q + PTR_W'(1);
    end
    if (rx_pop) begin
      rx_rd_ptr_d = rx_rd_ptr_q + PTR_W'(1);
      rx_cnt_d    = rx_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < RX_DEPTH; i++) begin
        rx_mem_q[i] <= '0;
      end
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_cnt_q    <= '0;
      rx_ovf_q    <= 1'b0;
      misroute_q  <= 1'b0;
    end else begin
      rx_mem_q    <= rx_mem_d;
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_ovf_q    <= rx_ovf_d;
      misroute_q  <= misroute_d;
    end
  end

  assign tx_ready_o    = tx_ready;
  assign sw_wr_en_o    = tx_wr_en;
  assign sw_pckt_o     = tx_pckt_q;
  assign tx_cnt_o      = tx_cnt_q;
  assign tx_err_o      = tx_err_q;
  assign sw_full_o     = rx_full;
  assign sw_overflow_o = rx_ovf_q;
  assign rx_valid_o    = rx_valid;
  assign rx_data_o     = rx_mem_q[rx_rd_ptr_q[RX_FIFO_DEPTH_W-1:0]];
  assign rx_cnt_o      = rx_cnt_q;
  assign misroute_o    = misroute_q;

endmodule

// File: tb/tb_noc_resource_iface.sv
// Directed bench for noc_resource_iface: a per-cycle vector table for TX streaming, TX backpressure
// and RX fill/overflow/drain, then hand-built sequences for push+pop at full, misroute, and async reset.
module tb_noc_resource_iface;

  logic        clk = 1'b0;
  logic        rstN;
  logic        txValid;
  logic        txReady;
  logic [3:0]  txDstX;
  logic [3:0]  txDstY;
  logic [7:0]  txData;
  logic        swWrEnOut;
  logic [15:0] swPcktOut;
  logic        swFullIn;
  logic        swOverflowIn;
  logic        swWrEnIn;
  logic [15:0] swPcktIn;
  logic        swFullOut;
  logic        swOverflowOut;
  logic        rxValid;
  logic        rxReady;
  logic [7:0]  rxData;
  logic        misroute;
  logic        txErr;
  logic [15:0] txCnt;
  logic [15:0] rxCnt;

  int assertCount = 0;
  int failCount   = 0;

  noc_resource_iface #(
    .X_CORD(0), .Y_CORD(0), .PCKT_XADDR_W(4), .PCKT_YADDR_W(4), .PCKT_DATA_W(8),
    .PCKT_W(16), .RX_FIFO_DEPTH_W(2), .CNT_W(16)
  ) dut (
    .clk_i(clk), .rst_ni(rstN),
    .tx_valid_i(txValid), .tx_ready_o(txReady),
    .tx_dst_x_i(txDstX), .tx_dst_y_i(txDstY), .tx_data_i(txData),
    .sw_wr_en_o(swWrEnOut), .sw_pckt_o(swPcktOut),
    .sw_full_i(swFullIn), .sw_overflow_i(swOverflowIn),
    .sw_wr_en_i(swWrEnIn), .sw_pckt_i(swPcktIn),
    .sw_full_o(swFullOut), .sw_overflow_o(swOverflowOut),
    .rx_valid_o(rxValid), .rx_ready_i(rxReady), .rx_data_o(rxData),
    .misroute_o(misroute), .tx_err_o(txErr),
    .tx_cnt_o(txCnt), .rx_cnt_o(rxCnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        txValid;
    logic [3:0]  txX;
    logic [3:0]  txY;
    logic [7:0]  txData;
    logic        swFull;
    logic        swOvf;
    logic        swWr;
    logic [15:0] swPckt;
    logic        rxReady;
    logic        eTxReady;
    logic        eSwWr;
    logic [15:0] eSwPckt;
    logic [15:0] eTxCnt;
    logic        eTxErr;
    logic        eSwFull;
    logic        eSwOvf;
    logic        eRxValid;
    logic [7:0]  eRxData;
    logic [15:0] eRxCnt;
    logic        eMisroute;
  } vec_t;

  // RX-centric vector with the TX side idle and expected in its post-reset state.
  function automatic vec_t rxStep(input logic swWr, input logic [15:0] pckt, input logic rdy,
                                  input logic eFull, input logic eOvf, input logic eValid,
                                  input logic [7:0] eData, input logic [15:0] eCnt,
                                  input logic eMis, input logic eErr);
    vec_t v;
    v = '{1'b0, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0, swWr, pckt, rdy,
          1'b1, 1'b0, 16'h0000, 16'd0, eErr, eFull, eOvf, eValid, eData, eCnt, eMis};
    return v;
  endfunction

  task automatic checkVal(input string name, input logic [15:0] act, input logic [15:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    txValid      = v.txValid;
    txDstX       = v.txX;
    txDstY       = v.txY;
    txData       = v.txData;
    swFullIn     = v.swFull;
    swOverflowIn = v.swOvf;
    swWrEnIn     = v.swWr;
    swPcktIn     = v.swPckt;
    rxReady      = v.rxReady;
  endtask

  task automatic checkOutput(input string tag, input vec_t v);
    checkVal({tag, " tx_ready"},    16'(txReady),       16'(v.eTxReady));
    checkVal({tag, " sw_wr_en"},    16'(swWrEnOut),     16'(v.eSwWr));
    checkVal({tag, " sw_pckt"},     swPcktOut,          v.eSwPckt);
    checkVal({tag, " tx_cnt"},      txCnt,              v.eTxCnt);
    checkVal({tag, " tx_err"},      16'(txErr),         16'(v.eTxErr));
    checkVal({tag, " sw_full"},     16'(swFullOut),     16'(v.eSwFull));
    checkVal({tag, " sw_overflow"}, 16'(swOverflowOut), 16'(v.eSwOvf));
    checkVal({tag, " rx_valid"},    16'(rxValid),       16'(v.eRxValid));
    if (v.eRxValid) checkVal({tag, " rx_data"}, 16'(rxData), 16'(v.eRxData));
    checkVal({tag, " rx_cnt"},      rxCnt,              v.eRxCnt);
    checkVal({tag, " misroute"},    16'(misroute),      16'(v.eMisroute));
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 3 units later.
  task automatic step(input string tag, input vec_t v);
    @(posedge clk);
    #1;
    applyStimulus(v);
    #3;
    checkOutput(tag, v);
  endtask

  task automatic doReset();
    rstN = 1'b0;
    applyStimulus(rxStep(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0, 16'd0, 1'b0, 1'b0));
    #1;
    checkOutput("in_reset", rxStep(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0, 16'd0, 1'b0, 1'b0));
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;
  endtask

  vec_t table_q [$];
  vec_t v;

  initial begin
    // {txValid,x,y,data,swFull,swOvf,swWr,swPckt,rxReady | eTxReady,eSwWr,eSwPckt,eTxCnt,eTxErr,eSwFull,eSwOvf,eRxValid,eRxData,eRxCnt,eMis}
    table_q.push_back('{1'b0,4'h0,4'h0,8'h00,1'b0,1'b0,1'b0,16'h0000,1'b0, 1'b1,1'b0,16'h0000,16'd0,1'b0,1'b0,1'b0,1'b0,8'h00,16'd0,1'b0});
    table_q.push_back('{1'b1,4'h2,4'h1,8'hA0,1'b0,1'b0,1'b0,16'h0000,1'b0, 1'b1,1'b0,16'h0000,16'd0,1'b0,1'b0,1'b0,1'b0,8'h00,16'd0,1'b0});
    table_q.push_back('{1'b1,4'h2,4'h1,8'hA1,1'b0,1'b0,1'b0,16'h0000,1'b0, 1'b1,1'b1,16'h21A0,16'd0,1'b0,1'b0,1'b0,1'b0,8'h00,16'd0,1'b0});
    table_q.push_back('{1'b1,4'h2,4'h1,8'hA2,1'b0,1'b0,1'b0,16'h0000,1'b0, 1'b1,1'b1,16'h21A1,16'd1,1'b0,1'b0,1'b0,1'b0,8'h00,16'd0,1'b0});
    table_q.push_back('{1'b0,4'h0,4'h0,8'h00,1'b0,1'b0,1'b0,16'h0000,1'b0, 1'b1,1'b1,16'h21A2,16'd2,1'b0,1'b0,1'b0,1'b0,8'h00,16'd0,1'b0});
    table_q.push_back('{1'b0,4'h0,4'h0,8'h00,1'b0,1'b0,1'b0,16'h0000,1'b0, 1'b1,1'b0,16'h21A2,16'd3,1'b0,1'b0,1'b0,1'b0,8'h00,16'd0,1'b0});
    table_q.push_back('{1'b1,4'h5,4'h6,8'h77,1'b0,1'b0,1'b0,16'h0000,1'b0, 1'b1,1'b0,16'h21A2,16'd3,1'b0,1'b0,1'b0,1'b0,8'h00,16'd0,1'b0});
    table_q.push_back('{1'b0,4'h0,4'h0,8'h00,1'b1,1'b0,1'b0,16'h0000,1'b0, 1'b0,1'b0,16'h5677,16'd3,1'b0,1'b0,1'b0,1'b0,8'h00,16'd0,1'b0});
    table_q.push_back('{1'b1,4'h9,4'h9,8'h99,1'b1,1'b0,1'b0,16'h0000,1'b0, 1'b0,1'b0,16'h5677,16'd3,1'b0,1'b0,1'b0,1'b0,8'h00,16'd0,1'b0});
    table_q.push_back('{1'b0,4'h0,4'h0,8'h00,1'b1,1'b0,1'b0,16'h0000,1'b0, 1'b0,1'b0,16'h5677,16'd3,1'b0,1'b0,1'b0,1'b0,8'h00,16'd0,1'b0});
    table_q.push_back('{1'b0,4'h0,4'h0,8'h00,1'b1,1'b0,1'b0,16'h0000,1'b0, 1'b0,1'b0,16'h5677,16'd3,1'b0,1'b0,1'b0,1'b0,8'h00,16'd0,1'b0});
    table_q.push_back('{1'b0,4'h0,4'h0,8'h00,1'b0,1'b0,1'b0,16'h0000,1'b0, 1'b1,1'b1,16'h5677,16'd3,1'b0,1'b0,1'b0,1'b0,8'h00,16'd0,1'b0});
    table_q.push_back('{1'b0,4'h0,4'h0,8'h00,1'b0,1'b0,1'b0,16'h0000,1'b0, 1'b1,1'b0,16'h5677,16'd4,1'b0,1'b0,1'b0,1'b0,8'h00,16'd0,1'b0});
    table_q.push_back('{1'b0,4'h0,4'h0,8'h00,1'b0,1'b0,1'b1,16'h0010,1'b0, 1'b1,1'b0,16'h5677,16'd4,1'b0,1'b0,1'b0,1'b0,8'h00,16'd0,1'b0});
    table_q.push_back('{1'b0,4'h0,4'h0,8'h00,1'b0,1'b0,1'b1,16'h0011,1'b0, 1'b1,1'b0,16'h5677,16'd4,1'b0,1'b0,1'b0,1'b1,8'h10,16'd0,1'b0});
    table_q.push_back('{1'b0,4'h0,4'h0,8'h00,1'b0,1'b0,1'b1,16'h0012,1'b0, 1'b1,1'b0,16'h5677,16'd4,1'b0,1'b0,1'b0,1'b1,8'h10,16'd0,1'b0});
    table_q.push_back('{1'b0,4'h0,4'h0,8'h00,1'b0,1'b0,1'b1,16'h0013,1'b0, 1'b1,1'b0,16'h5677,16'd4,1'b0,1'b0,1'b0,1'b1,8'h10,16'd0,1'b0});
    table_q.push_back('{1'b0,4'h0,4'h0,8'h00,1'b0,1'b0,1'b1,16'h0014,1'b0, 1'b1,1'b0,16'h5677,16'd4,1'b0,1'b1,1'b0,1'b1,8'h10,16'd0,1'b0});
    table_q.push_back('{1'b0,4'h0,4'h0,8'h00,1'b0,1'b0,1'b0,16'h0000,1'b0, 1'b1,1'b0,16'h5677,16'd4,1'b0,1'b1,1'b1,1'b1,8'h10,16'd0,1'b0});
    table_q.push_back('{1'b0,4'h0,4'h0,8'h00,1'b0,1'b0,1'b0,16'h0000,1'b1, 1'b1,1'b0,16'h5677,16'd4,1'b0,1'b1,1'b1,1'b1,8'h10,16'd0,1'b0});
    table_q.push_back('{1'b0,4'h0,4'h0,8'h00,1'b0,1'b0,1'b0,16'h0000,1'b1, 1'b1,1'b0,16'h5677,16'd4,1'b0,1'b0,1'b1,1'b1,8'h11,16'd1,1'b0});
    table_q.push_back('{1'b0,4'h0,4'h0,8'h00,1'b0,1'b0,1'b0,16'h0000,1'b1, 1'b1,1'b0,16'h5677,16'd4,1'b0,1'b0,1'b1,1'b1,8'h12,16'd2,1'b0});
    table_q.push_back('{1'b0,4'h0,4'h0,8'h00,1'b0,1'b0,1'b0,16'h0000,1'b1, 1'b1,1'b0,16'h5677,16'd4,1'b0,1'b0,1'b1,1'b1,8'h13,16'd3,1'b0});
    table_q.push_back('{1'b0,4'h0,4'h0,8'h00,1'b0,1'b0,1'b0,16'h0000,1'b1, 1'b1,1'b0,16'h5677,16'd4,1'b0,1'b0,1'b1,1'b0,8'h00,16'd4,1'b0});

    doReset();
    for (int i = 0; i < table_q.size(); i++) begin
      step($sformatf("row%0d", i), table_q[i]);
    end

    // FIFO full with simultaneous push and pop: no overflow, new entry drains last.
    doReset();
    step("pp_fill0", rxStep(1'b1, 16'h0020, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'd0, 1'b0, 1'b0));
    step("pp_fill1", rxStep(1'b1, 16'h0021, 1'b0, 1'b0, 1'b0, 1'b1, 8'h20, 16'd0, 1'b0, 1'b0));
    step("pp_fill2", rxStep(1'b1, 16'h0022, 1'b0, 1'b0, 1'b0, 1'b1, 8'h20, 16'd0, 1'b0, 1'b0));
    step("pp_fill3", rxStep(1'b1, 16'h0023, 1'b0, 1'b0, 1'b0, 1'b1, 8'h20, 16'd0, 1'b0, 1'b0));
    step("pp_both",  rxStep(1'b1, 16'h0024, 1'b1, 1'b1, 1'b0, 1'b1, 8'h20, 16'd0, 1'b0, 1'b0));
    step("pp_after", rxStep(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 8'h21, 16'd1, 1'b0, 1'b0));
    step("pp_drain0", rxStep(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 8'h21, 16'd1, 1'b0, 1'b0));
    step("pp_drain1", rxStep(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 8'h22, 16'd2, 1'b0, 1'b0));
    step("pp_drain2", rxStep(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 8'h23, 16'd3, 1'b0, 1'b0));
    step("pp_drain3", rxStep(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 8'h24, 16'd4, 1'b0, 1'b0));
    step("pp_empty", rxStep(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'd5, 1'b0, 1'b0));

    // Misrouted packet is still delivered; sw_overflow_i pulse sets tx_err.
    step("mis_push", rxStep(1'b1, 16'h3055, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'd5, 1'b0, 1'b0));
    step("mis_flag", rxStep(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 8'h55, 16'd5, 1'b1, 1'b0));
    step("mis_pop",  rxStep(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 8'h55, 16'd5, 1'b1, 1'b0));
    v = rxStep(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'd6, 1'b1, 1'b0);
    v.swOvf = 1'b1;
    step("err_pulse", v);
    step("err_flag", rxStep(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'd6, 1'b1, 1'b1));

    // Asynchronous reset between edges with a loaded TX register and a non-empty RX FIFO.
    v = rxStep(1'b1, 16'h0042, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'd6, 1'b1, 1'b1);
    v.txValid = 1'b1;
    v.txX = 4'h1;
    v.txY = 4'h2;
    v.txData = 8'h33;
    v.swFull = 1'b1;
    step("rst_setup0", v);
    v = rxStep(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 8'h42, 16'd6, 1'b1, 1'b1);
    v.swFull = 1'b1;
    v.eTxReady = 1'b0;
    v.eSwPckt = 16'h1233;
    step("rst_setup1", v);
    #3;
    rstN = 1'b0;
    applyStimulus(rxStep(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0, 16'd0, 1'b0, 1'b0));
    #1;
    checkOutput("async_rst", rxStep(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0, 16'd0, 1'b0, 1'b0));
    @(negedge clk);
    rstN = 1'b1;

    v = rxStep(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'd0, 1'b0, 1'b0);
    v.txValid = 1'b1;
    v.txData = 8'hEE;
    step("post_rst_tx0", v);
    v = rxStep(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'd0, 1'b0, 1'b0);
    v.eSwWr = 1'b1;
    v.eSwPckt = 16'h00EE;
    step("post_rst_tx1", v);
    v.eSwWr = 1'b0;
    v.eTxCnt = 16'd1;
    step("post_rst_tx2", v);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
